// File: rtl/vram_arbiter_pkg.sv
// Shared tile-grid constants and clear-engine state type for the VRAM arbiter.
package vram_arbiter_pkg;

    localparam int TILE_COLS  = 40;
    localparam int TILE_ROWS  = 30;
    localparam int TILE_COUNT = TILE_COLS * TILE_ROWS;
    localparam int TILE_SHIFT = 4;

    typedef enum logic [1:0] {
        C_IDLE,
        C_RUN,
        C_DONE
    } clear_state_t;

    // row*40 + col as row*32 + row*8 + col
    function automatic logic [15:0] tile_index(input logic [5:0] row,
                                               input logic [5:0] col);
        logic [15:0] r;
        r = {10'd0, row};
        return (r << 5) + (r << 3) + {10'd0, col};
    endfunction

endpackage

// File: rtl/vram_clear_engine.sv
// Sweeps every tile address once, writing one word per acknowledged free slot.
module vram_clear_engine
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    input  logic              ack,
    output logic              clr_req,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clear_busy,
    output logic              clear_done
);

    clear_state_t      state;
    clear_state_t      next_state;
    logic [ADDR_W-1:0] cnt;
    logic              last;

    assign last     = (cnt == ADDR_W'(TILE_COUNT - 1));
    assign clr_addr = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= C_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == C_RUN && ack) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            C_IDLE:  if (clear_start) next_state = C_RUN;
            C_RUN:   if (ack && last) next_state = C_DONE;
            C_DONE:  next_state = C_IDLE;
            default: next_state = C_IDLE;
        endcase
    end

    always_comb begin
        clr_req    = 1'b0;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        unique case (state)
            C_RUN: begin
                clr_req    = 1'b1;
                clear_busy = 1'b1;
            end
            C_DONE: begin
                clear_busy = 1'b1;
                clear_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vram_arbiter.sv
// Tile-RAM port sharing: display fetch, clear engine, two requesters.
// Define VRAM_ARB_RR_EN for round-robin requesters; default is fixed priority.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 11,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              disp_slot;
    logic [ADDR_W-1:0] disp_addr;
    logic              clr_req;
    logic              clr_ack;
    logic [ADDR_W-1:0] clr_addr;
    logic              arb_ok;
    logic              sel_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_valid;
    logic              rd_tag;
    logic [DATA_W-1:0] rdata_q;
    logic              disp_pend;
    logic [DATA_W-1:0] disp_q;
    logic              unused_bits;

    assign unused_bits = ^{pixel_x[TILE_SHIFT-1:0], pixel_y[TILE_SHIFT-1:0]};

    assign disp_slot = p_tick & video_on;
    assign disp_addr = ADDR_W'(tile_index(pixel_y[9:TILE_SHIFT],
                                          pixel_x[9:TILE_SHIFT]));

    vram_clear_engine #(
        .ADDR_W(ADDR_W)
    ) u_clear (
        .clk        (clk),
        .reset      (reset),
        .clear_start(clear_start),
        .ack        (clr_ack),
        .clr_req    (clr_req),
        .clr_addr   (clr_addr),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
    );

    assign clr_ack = clr_req & ~disp_slot;
    assign arb_ok  = ~disp_slot & ~clear_busy & (|req);

`ifdef VRAM_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (arb_ok) begin
            rr_ptr <= ~sel_idx;
        end
    end

    assign sel_idx = (req == 2'b11) ? rr_ptr : req[1];
`else
    assign sel_idx = ~req[0];
`endif

    assign gnt       = arb_ok ? (sel_idx ? 2'b10 : 2'b01) : 2'b00;
    assign sel_we    = sel_idx ? we[1]  : we[0];
    assign sel_addr  = sel_idx ? addr1  : addr0;
    assign sel_wdata = sel_idx ? wdata1 : wdata0;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            disp_slot: begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end
            clr_ack: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = CLEAR_VAL;
            end
            arb_ok: begin
                mem_en    = 1'b1;
                mem_we    = sel_we;
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_tag    <= 1'b0;
            rdata_q   <= '0;
            disp_pend <= 1'b0;
            disp_q    <= '0;
        end else begin
            rd_valid  <= arb_ok & ~sel_we;
            disp_pend <= disp_slot;
            if (arb_ok) rd_tag <= sel_idx;
            if (rd_valid) rdata_q <= mem_rdata;
            if (disp_pend) disp_q <= mem_rdata;
        end
    end

    // RAM output is live only in the return cycle; the register holds it after
    assign rvalid     = {rd_valid & rd_tag, rd_valid & ~rd_tag};
    assign rdata      = rd_valid ? mem_rdata : rdata_q;
    assign disp_valid = disp_pend;
    assign disp_data  = disp_pend ? mem_rdata : disp_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency tile RAM.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [10:0] addr0;
    logic [10:0] addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic        clear_start;
    logic        clear_busy;
    logic        clear_done;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:2047];

    int n_checks;
    int n_errors;
    int n_wr;
    int bad;
    int exp_addr;
    bit found;
    bit done_seen;
    logic [1:0] exp_gnt [0:3];

    vram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .req        (req),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            logic [10:0] a;
            a = 11'(i);
            ram[i] = a[7:0] ^ 8'hA5;
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        p_tick = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
        req = 0; we = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        clear_start = 0;
`ifdef VRAM_ARB_RR_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10;
        exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01;
        exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`endif

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_busy", clear_busy, 0);
        @(negedge clk); reset = 1'b0;

        // single read from requester 0
        @(negedge clk); req = 2'b01; addr0 = 11'd5; #1;
        check("rd_gnt", gnt, 2'b01);
        check("rd_mem_addr", mem_addr, 5);
        check("rd_mem_we", {mem_en, mem_we}, 2'b10);
        @(negedge clk); req = 2'b00; #1;
        check("rd_rvalid", rvalid, 2'b01);
        check("rd_rdata", rdata, 8'hA0);
        @(negedge clk); #1;
        check("rd_rvalid_pulse", rvalid, 0);

        // reset discards pending read
        @(negedge clk); req = 2'b01; addr0 = 11'd7; #1;
        check("pr_gnt", gnt, 2'b01);
        @(negedge clk); req = 2'b00; reset = 1'b1; #1;
        check("pr_rvalid_in_rst", rvalid, 0);
        @(negedge clk); reset = 1'b0; #1;
        check("pr_rvalid_after", rvalid, 0);

        // both requesters held over four free slots
        addr0 = 11'd5; addr1 = 11'd100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); req = 2'b11; #1;
            check($sformatf("both_gnt%0d", i), gnt, exp_gnt[i]);
            if (i > 0) begin
                check($sformatf("both_rv%0d", i), rvalid, exp_gnt[i-1]);
                check($sformatf("both_rd%0d", i), rdata,
                      exp_gnt[i-1] == 2'b01 ? 8'hA0 : 8'hC1);
            end
        end
        @(negedge clk); req = 2'b00; #1;

        // display slot blocks a pending request
        @(negedge clk);
        p_tick = 1; video_on = 1; pixel_x = 10'd37; pixel_y = 10'd20;
        req = 2'b01; addr0 = 11'd5; #1;
        check("dsp_mem_addr", mem_addr, 42);
        check("dsp_mem_en_we", {mem_en, mem_we}, 2'b10);
        check("dsp_gnt_blocked", gnt, 0);
        @(negedge clk); p_tick = 0; #1;
        check("dsp_valid", disp_valid, 1);
        check("dsp_data", disp_data, 8'h8F);
        check("dsp_late_gnt", gnt, 2'b01);
        @(negedge clk); req = 2'b00; video_on = 0; #1;
        check("dsp_valid_pulse", disp_valid, 0);
        check("dsp_data_hold", disp_data, 8'h8F);
        check("dsp_late_rv", rvalid, 2'b01);
        check("dsp_late_rd", rdata, 8'hA0);

        // write from requester 1 then read it back
        @(negedge clk); req = 2'b10; we = 2'b10; addr1 = 11'd100;
        wdata1 = 8'h3C; #1;
        check("wr_gnt", gnt, 2'b10);
        check("wr_mem_we", {mem_en, mem_we}, 2'b11);
        check("wr_mem_addr", mem_addr, 100);
        check("wr_mem_wdata", mem_wdata, 8'h3C);
        @(negedge clk); we = 2'b00; #1;
        check("wr_no_rvalid", rvalid, 0);
        check("wr_rd_gnt", gnt, 2'b10);
        @(negedge clk); req = 2'b00; #1;
        check("wr_rd_rvalid", rvalid, 2'b10);
        check("wr_rd_data", rdata, 8'h3C);

        // reset in the middle of a clear
        @(negedge clk); clear_start = 1; #1;
        check("mc_idle_busy", clear_busy, 0);
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk); clear_start = 0; #1;
            if (mem_en && mem_we && mem_addr == 11'd600) found = 1;
        end
        check("mc_reach600", found, 1);
        reset = 1'b1; #1;
        check("mc_busy_rst", clear_busy, 0);
        check("mc_mem_en_rst", mem_en, 0);
        @(negedge clk); reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (clear_done || clear_busy || mem_en) bad++;
        end
        check("mc_quiet_after", bad, 0);
        check("mc_ram599", ram[599], 8'h00);
        check("mc_ram600", ram[600], 8'hFD);

        // full clear with both requesters asking
        @(negedge clk); clear_start = 1; req = 2'b00; #1;
        n_wr = 0; bad = 0; exp_addr = 0; done_seen = 0;
        for (int c = 0; c < 1400 && !done_seen; c++) begin
            @(negedge clk); clear_start = 0; req = 2'b11; #1;
            if (gnt != 2'b00) bad++;
            if (mem_en && mem_we) begin
                if (mem_addr != 11'(exp_addr) || mem_wdata != 8'h00) bad++;
                exp_addr++;
                n_wr++;
            end
            if (clear_done) done_seen = 1;
        end
        check("clr_done_seen", done_seen, 1);
        check("clr_writes", n_wr, 1200);
        check("clr_bad", bad, 0);
        @(negedge clk); req = 2'b01; addr0 = 11'd5; #1;
        check("clr_done_pulse", clear_done, 0);
        check("clr_busy_end", clear_busy, 0);
        check("clr_gnt_resume", gnt, 2'b01);
        @(negedge clk); req = 2'b00; #1;
        check("clr_rd_rvalid", rvalid, 2'b01);
        check("clr_rd_data", rdata, 8'h00);
        check("clr_ram1199", ram[1199], 8'h00);
        check("clr_ram1200", ram[1200], 8'h15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, tile-RAM word width.
REQ-002 Parameter ADDR_W, default 11, tile-RAM address width; 1200 tiles, 40x30 grid of 16x16 px.
REQ-003 Parameter CLEAR_VAL, default 0, word written by clear engine.
REQ-004 clk  input  1  system clock; reset  input  1  asynchronous, active-high.
REQ-005 p_tick  input  1  pixel enable from VGA timing; video_on  input  1  active-area flag.
REQ-006 pixel_x, pixel_y  input  10 each  current pixel counters.
REQ-007 disp_data  output  DATA_W  tile word for current display tile; disp_valid  output  1  one-cycle pulse on disp_data update.
REQ-008 req  input  2  per-requester access request; we  input  2  per-requester write flag.
REQ-009 addr0, addr1  input  ADDR_W; wdata0, wdata1  input  DATA_W  requester address/data.
REQ-010 gnt  output  2  one-hot grant; rvalid  output  2  read-return pulse; rdata  output  DATA_W  read data.
REQ-011 clear_start  input  1  start full-RAM clear; clear_busy  output  1; clear_done  output  1  one-cycle pulse.
REQ-012 mem_en, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W  single-port RAM, 1-cycle read latency.

Function
REQ-013 Display slot = cycle with p_tick=1 and video_on=1; all other cycles are free slots.
REQ-014 Display slot: mem_en=1, mem_we=0, mem_addr=(pixel_y>>4)*40+(pixel_x>>4); no requester or clear access issued.
REQ-015 Cycle after display slot: disp_data<=mem_rdata, disp_valid=1; disp_data holds otherwise.
REQ-016 Free-slot priority: clear engine (while clear_busy) > requesters > idle (mem_en=0).
REQ-017 Requester handshake: requester holds req/we/addr/wdata stable until gnt; gnt bit asserted combinationally in the issuing cycle only; requester drops or re-presents req next cycle.
REQ-018 Granted write: mem_we=1, mem_addr/mem_wdata from that requester; no rvalid.
REQ-019 Granted read: next cycle rvalid[i]=1, rdata=mem_rdata; owner tracked by 1-bit tag register plus valid bit.
REQ-020 gnt=0 in display slots and while clear_busy, regardless of req.
REQ-021 Clear FSM: C_IDLE -> C_RUN on clear_start; C_RUN writes CLEAR_VAL at counter address 0..1199, incrementing one per free slot; at 1199 written -> C_DONE; C_DONE -> C_IDLE after one cycle with clear_done=1.
REQ-022 clear_busy=1 in C_RUN and C_DONE; clear_start while busy ignored.
REQ-023 Addresses >=1200 from requesters pass through unchecked; counter never exceeds 1199.

Reset
REQ-024 On reset: disp_data=0, disp_valid=0, gnt=0, rvalid=0, rdata=0, clear FSM C_IDLE, counter 0, read tag invalid, round-robin pointer at requester 0.
REQ-025 Reset asserted mid-clear aborts clear; no clear_done issued; RAM partially cleared.
REQ-026 Reset asserted with pending read discards it; no rvalid after release.

Configuration
REQ-027 Macro VRAM_ARB_RR_EN defined: round-robin between requesters; pointer moves to other requester after each grant.
REQ-028 Macro VRAM_ARB_RR_EN undefined: fixed priority, requester 0 over requester 1; no pointer register.

Structure
REQ-029 Shared package holds TILE_COLS=40, TILE_ROWS=30, TILE_COUNT=1200, TILE_SHIFT=4, clear-state enum.
REQ-030 Clear engine is a sub-module vram_clear_engine (FSM+counter, request/ack to arbiter); address multiply uses shift-add (x32+x8).

Verification
REQ-031 pixel_x=37, pixel_y=20, video_on=1, p_tick=1 -> mem_addr=42, mem_we=0; next cycle disp_valid=1, disp_data=mem_rdata.
REQ-032 req=2'b01, we=0, addr0=5 in free slot -> gnt=2'b01 same cycle, rvalid=2'b01 next cycle with RAM[5].
REQ-033 req=2'b11 held over four free slots, RR enabled -> grants 01,10,01,10; RR disabled -> 01 every slot.
REQ-034 clear_start pulse, video_on=0 -> 1200 writes of CLEAR_VAL, addresses 0..1199, clear_done pulse, gnt=0 throughout.
REQ-035 Reset asserted at clear counter 600 -> clear_busy=0 after reset, no clear_done, counter 0.
REQ-036 req=2'b01 during display slot -> gnt=0 that cycle, granted in next free slot.
